fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS datapath: holds the program counter and drives it into the 32-bit PC+4 adder. It consumes the adder's sum as the sequential next PC, requests instruction words from instruction memory, and hands them to decode over a valid/ready interface. Taken branches and jumps from downstream redirect it. A 2-entry buffer absorbs decode stalls without losing a returned word.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 70 +++++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared MIPS datapath types and constants
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DROP  = 2'd2,
    S_STALL = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(WORD_BYTES - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf : 2-entry {instr, pc} FIFO between fetch and decode
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [1:0]      o_count
);

  logic [XLEN-1:0] r_instr [2];
  logic [XLEN-1:0] r_pc    [2];
  logic [1:0]      r_count;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
      r_pc[0]    <= '0;
      r_pc[1]    <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10: begin
          r_instr[r_count[0]] <= i_instr;
          r_pc[r_count[0]]    <= i_pc;
          r_count             <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr[0] <= r_instr[1];
          r_pc[0]    <= r_pc[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_instr[0] <= i_instr;
            r_pc[0]    <= i_pc;
          end else begin
            r_instr[0] <= r_instr[1];
            r_pc[0]    <= r_pc[1];
            r_instr[1] <= i_instr;
            r_pc[1]    <= i_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_instr = r_instr[0];
  assign o_pc    = r_pc[0];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : MIPS instruction-fetch stage with PC, imem handshake and skid
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [1:0]      w_count;
  logic [1:0]      w_count_nxt;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_target;

  assign w_pop       = inst_valid_o & inst_ready_i;
  assign w_push      = (r_state == S_REQ) && imem_ack_i && !redirect_i;
  assign w_target    = word_align(redirect_pc_i);
  assign w_count_nxt = w_count + {1'b0, w_push} - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      if (redirect_i) begin
        r_pc <= w_target;
      end else if (w_push) begin
        r_pc <= pc_plus4_i;
      end

      unique case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // A redirect racing an outstanding request must swallow that ack.
          if (redirect_i) begin
            r_state <= imem_ack_i ? S_REQ : S_DROP;
          end else if (imem_ack_i && (w_count_nxt == 2'd2)) begin
            r_state <= S_STALL;
          end
        end
        S_DROP: begin
          if (imem_ack_i) r_state <= S_REQ;
        end
        S_STALL: begin
          if (redirect_i || w_pop) r_state <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_instr (imem_rdata_i),
    .i_pc    (r_pc),
    .o_instr (inst_o),
    .o_pc    (inst_pc_o),
    .o_count (w_count)
  );

  assign pc_o         = r_pc;
  assign imem_addr_o  = r_pc;
  assign imem_req_o   = (r_state == S_REQ) || (r_state == S_DROP);
  assign inst_valid_o = (w_count != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit with a variable-latency imem
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int          mem_lat  = 0;
  int          mem_wait = 0;
  int          n_cmp    = 0;
  int          n_err    = 0;
  int          n_pops   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  assign pc_plus4   = pc + 32'd4;
  assign imem_ack   = imem_req && (mem_wait >= mem_lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) mem_wait <= 0;
    else                              mem_wait <= mem_wait + 1;
  end

  fetch_unit #(.RESET_PC(RST_PC)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc),
    .pc_plus4_i    (pc_plus4),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_seed(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each accepted word must be the next PC of the current stream.
  always @(negedge clk) begin
    if (rst) begin
      sb_seed(RST_PC);
    end else begin
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check_value("sb_underflow", 32'd0, 32'd1);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check_value("sb_pc", inst_pc, e);
          check_value("sb_inst", inst, mem_word(e));
          n_pops++;
          if (exp_q.size() < 4) begin
            logic [31:0] last;
            last = exp_q.size() > 0 ? exp_q[$] : e;
            for (int i = 1; i <= 8; i++) exp_q.push_back(last + 32'(i * 4));
          end
        end
      end
      if (redirect) sb_seed({redirect_pc[31:2], 2'b00});
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int pops0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_pc", pc, RST_PC);
    check_value("rst_req", 32'(imem_req), 32'd0);
    check_value("rst_valid", 32'(inst_valid), 32'd0);
    check_value("rst_inst", inst, 32'd0);
    check_value("rst_inst_pc", inst_pc, 32'd0);

    // Stream with zero-wait memory.
    step(); rst = 1'b0;
    @(negedge clk);
    check_value("a_c0_req", 32'(imem_req), 32'd0);
    check_value("a_c0_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check_value("a_c1_req", 32'(imem_req), 32'd1);
    check_value("a_c1_addr", imem_addr, RST_PC);
    check_value("a_c1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check_value("a_c2_valid", 32'(inst_valid), 32'd1);
    check_value("a_c2_pc", inst_pc, RST_PC);
    @(negedge clk);
    check_value("a_c3_pc", inst_pc, RST_PC + 32'd4);
    @(negedge clk);
    check_value("a_c4_pc", inst_pc, RST_PC + 32'd8);

    // Backpressure from the start of a fresh run.
    step(); rst = 1'b1; inst_ready = 1'b0;
    step(); rst = 1'b0;
    repeat (4) @(negedge clk);
    check_value("b_req", 32'(imem_req), 32'd0);
    check_value("b_pc", pc, RST_PC + 32'd8);
    check_value("b_valid", 32'(inst_valid), 32'd1);
    check_value("b_head", inst_pc, RST_PC);
    @(negedge clk);
    check_value("b_req_hold", 32'(imem_req), 32'd0);
    pops0 = n_pops;
    step(); inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    check_value("b_drain", 32'((n_pops - pops0) >= 5), 32'd1);

    // Redirect during the second wait cycle of a 3-cycle memory.
    step(); mem_lat = 3;
    k = 0;
    @(negedge clk);
    while (!(imem_req && !imem_ack) && k < 20) begin @(negedge clk); k++; end
    check_value("c_wait_seen", 32'(imem_req && !imem_ack), 32'd1);
    step(); redirect = 1'b1; redirect_pc = 32'h0040_0100;
    step(); redirect = 1'b0;
    k = 0;
    @(negedge clk);
    while (!imem_ack && k < 20) begin @(negedge clk); k++; end
    check_value("c_ack_seen", 32'(imem_ack), 32'd1);
    @(negedge clk);
    check_value("c_req", 32'(imem_req), 32'd1);
    check_value("c_addr", imem_addr, 32'h0040_0100);
    k = 0;
    while (!inst_valid && k < 20) begin @(negedge clk); k++; end
    check_value("c_first_pc", inst_pc, 32'h0040_0100);

    // Redirect coinciding with an ack.
    step(); mem_lat = 0;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    @(negedge clk);
    check_value("d_req_ack", {30'd0, imem_req, imem_ack}, 32'd3);
    step(); redirect = 1'b0;
    @(negedge clk);
    check_value("d_flushed", 32'(inst_valid), 32'd0);
    check_value("d_addr", imem_addr, 32'h0040_0200);
    @(negedge clk);
    check_value("d_first_pc", inst_pc, 32'h0040_0200);

    // Misaligned target.
    step(); redirect = 1'b1; redirect_pc = 32'h0040_0103;
    step(); redirect = 1'b0;
    @(negedge clk);
    check_value("e_addr", imem_addr, 32'h0040_0100);
    @(negedge clk);
    check_value("e_first_pc", inst_pc, 32'h0040_0100);

    // Address wrap.
    step(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0;
    @(negedge clk);
    check_value("f_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check_value("f_pc_top", inst_pc, 32'hFFFF_FFFC);
    check_value("f_pc_wrapped", pc, 32'h0000_0000);
    @(negedge clk);
    check_value("f_pc_zero", inst_pc, 32'h0000_0000);

    // Reset mid-stream.
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_value("g_pc", pc, RST_PC);
    check_value("g_req", 32'(imem_req), 32'd0);
    check_value("g_valid", 32'(inst_valid), 32'd0);
    check_value("g_inst", inst, 32'd0);
    check_value("g_inst_pc", inst_pc, 32'd0);
    pops0 = n_pops;
    step(); rst = 1'b0;
    repeat (6) @(negedge clk);
    check_value("g_restart", 32'((n_pops - pops0) >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
